// File: rtl/bpred_pkg.sv
// Shared branch-predictor types: controller state, checkpoint layout and GHR reset value.
package bpred_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bpred_state_e;

  localparam int   BPRED_WIDTH_DEF = 8;
  localparam logic GHR_RESET_BIT   = 1'b1;

  // Default-width checkpoint; the controller declares the same layout at its own width.
  typedef struct packed {
    logic [BPRED_WIDTH_DEF-1:0] hist;
    logic                       pred;
  } ckpt_def_t;

  function automatic int ckpt_bits(input int ghr_w);
    return ghr_w + 1;
  endfunction

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// Checkpoint FIFO for in-flight branches: push/pop with a one-cycle flush of all entries.
module ghr_ckpt_fifo
  import bpred_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  // Entry storage carries no reset; only pointers and count are control state.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ghr_spec_ctrl.sv
// Speculative GHR controller: speculative shift on DEC prediction, checkpoint per branch, repair on mispredict.
// Optional GHR_PERF_CNT_EN adds 32-bit resolve and mispredict counters.
module ghr_spec_ctrl
  import bpred_pkg::*;
#(
  parameter int BPRED_WIDTH = 8,
  parameter int CKPT_DEPTH  = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic                          i_DEC_Is_Branch,
  input  logic                          i_DEC_Stall,
  input  logic                          i_Prediction,
  input  logic                          i_ALU_Branch_Valid,
  input  logic                          i_ALU_Branch_Outcome,
  output logic [BPRED_WIDTH-1:0]        o_Global_History,
  output logic                          o_Mispredict,
  output logic                          o_Hist_Full,
  output logic                          o_Recovering,
  output logic [$clog2(CKPT_DEPTH):0]   o_Inflight,
`ifdef GHR_PERF_CNT_EN
  output logic [31:0]                   o_Branch_Cnt,
  output logic [31:0]                   o_Mispredict_Cnt,
`endif
  output logic                          o_Resolve_Err
);

  localparam int CW = $clog2(CKPT_DEPTH) + 1;

  typedef struct packed {
    logic [BPRED_WIDTH-1:0] hist;
    logic                   pred;
  } ckpt_t;

  bpred_state_e    state;
  ckpt_t           head;
  ckpt_t           new_ckpt;
  logic [CW-1:0]   count;
  logic            in_run;
  logic            resolve_ok;
  logic            mispred;
  logic            push;
  logic            pop;
  logic            resolve_err;

  assign in_run      = (state == RUN);
  assign o_Hist_Full = (count == CW'(CKPT_DEPTH));
  assign o_Inflight  = count;

  // Compare is against the prediction stored at push time, never the live i_Prediction.
  assign resolve_ok  = in_run && i_ALU_Branch_Valid && (count != '0);
  assign resolve_err = in_run && i_ALU_Branch_Valid && (count == '0);
  assign mispred     = resolve_ok && (head.pred != i_ALU_Branch_Outcome);
  assign pop         = resolve_ok && !mispred;
  assign push        = in_run && i_DEC_Is_Branch && !i_DEC_Stall && !o_Hist_Full && !mispred;

  assign new_ckpt.hist = o_Global_History;
  assign new_ckpt.pred = i_Prediction;

  ghr_ckpt_fifo #(
    .WIDTH (ckpt_bits(BPRED_WIDTH)),
    .DEPTH (CKPT_DEPTH)
  ) u_ckpt_fifo (
    .clk   (i_Clk),
    .rst   (i_Reset),
    .flush (mispred),
    .push  (push),
    .pop   (pop),
    .wdata (new_ckpt),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state            <= RUN;
      o_Global_History <= {BPRED_WIDTH{GHR_RESET_BIT}};
      o_Mispredict     <= 1'b0;
      o_Resolve_Err    <= 1'b0;
      o_Recovering     <= 1'b0;
    end else begin
      o_Mispredict  <= mispred;
      o_Resolve_Err <= resolve_err;
      unique case (state)
        RUN: begin
          if (mispred) begin
            state            <= RECOVER;
            o_Recovering     <= 1'b1;
            o_Global_History <= BPRED_WIDTH'({head.hist, i_ALU_Branch_Outcome});
          end else if (push) begin
            o_Global_History <= BPRED_WIDTH'({o_Global_History, i_Prediction});
          end
        end
        RECOVER: begin
          state        <= RUN;
          o_Recovering <= 1'b0;
        end
        default: begin
          state        <= RUN;
          o_Recovering <= 1'b0;
        end
      endcase
    end
  end

`ifdef GHR_PERF_CNT_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Branch_Cnt     <= '0;
      o_Mispredict_Cnt <= '0;
    end else begin
      if (resolve_ok) o_Branch_Cnt     <= o_Branch_Cnt + 32'd1;
      if (mispred)    o_Mispredict_Cnt <= o_Mispredict_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ghr_spec_ctrl.sv
// Bench for ghr_spec_ctrl: directed vector table, reset corner, then random traffic vs a queue model.
module tb_ghr_spec_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         br, st, pr, vld, oc;
  logic [W-1:0] ghr;
  logic         misp, full, recov, rerr;
  logic [2:0]   infl;
`ifdef GHR_PERF_CNT_EN
  logic [31:0]  bcnt, mcnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ghr_spec_ctrl #(.BPRED_WIDTH(W), .CKPT_DEPTH(D)) dut (
    .i_Clk                (clk),
    .i_Reset              (rst),
    .i_DEC_Is_Branch      (br),
    .i_DEC_Stall          (st),
    .i_Prediction         (pr),
    .i_ALU_Branch_Valid   (vld),
    .i_ALU_Branch_Outcome (oc),
    .o_Global_History     (ghr),
    .o_Mispredict         (misp),
    .o_Hist_Full          (full),
    .o_Recovering         (recov),
    .o_Inflight           (infl),
`ifdef GHR_PERF_CNT_EN
    .o_Branch_Cnt         (bcnt),
    .o_Mispredict_Cnt     (mcnt),
`endif
    .o_Resolve_Err        (rerr)
  );

  // in = {br, stall, pred, valid, outcome}; flags = {mispredict, full, recovering, resolve_err}
  typedef struct {
    logic [4:0]   in;
    logic [W-1:0] ghr;
    logic [2:0]   infl;
    logic [3:0]   flags;
  } vec_t;

  typedef struct {
    logic [W-1:0] hist;
    logic         pred;
  } mentry_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eg, input logic [2:0] ei,
                         input logic [3:0] ef);
    chk({tag, " ghr"},   int'(ghr),   int'(eg));
    chk({tag, " infl"},  int'(infl),  int'(ei));
    chk({tag, " misp"},  int'(misp),  int'(ef[3]));
    chk({tag, " full"},  int'(full),  int'(ef[2]));
    chk({tag, " recov"}, int'(recov), int'(ef[1]));
    chk({tag, " rerr"},  int'(rerr),  int'(ef[0]));
  endtask

  task automatic step(input logic [4:0] in);
    {br, st, pr, vld, oc} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {br, st, pr, vld, oc} = 5'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model state
  mentry_t      q[$];
  int           m_ghr;
  bit           m_recov;
  bit           m_misp, m_err;
  int unsigned  m_bcnt, m_mcnt;

  task automatic model_step(input bit b, input bit s, input bit p, input bit v, input bit o);
    bit      res, pushed;
    mentry_t e;
    m_misp = 0;
    m_err  = 0;
    if (m_recov) begin
      m_recov = 0;
    end else begin
      res    = v && (q.size() > 0);
      m_err  = v && (q.size() == 0);
      m_misp = res && (q[0].pred != o);
      pushed = b && !s && (q.size() < D) && !m_misp;
      if (res) m_bcnt++;
      if (m_misp) begin
        m_mcnt++;
        m_ghr = ((int'(q[0].hist) * 2) + int'(o)) % (1 << W);
        q.delete();
        m_recov = 1;
      end else begin
        if (res) void'(q.pop_front());
        if (pushed) begin
          e.hist = W'(m_ghr);
          e.pred = p;
          q.push_back(e);
          m_ghr = ((m_ghr * 2) + int'(p)) % (1 << W);
        end
      end
    end
  endtask

  initial begin
    vecs[0]  = '{5'b10100, 8'hFF, 3'd1, 4'b0000}; // push 1
    vecs[1]  = '{5'b10000, 8'hFE, 3'd2, 4'b0000}; // push 0
    vecs[2]  = '{5'b10100, 8'hFD, 3'd3, 4'b0000}; // push 1
    vecs[3]  = '{5'b00011, 8'hFD, 3'd2, 4'b0000}; // correct resolve
    vecs[4]  = '{5'b00011, 8'hFF, 3'd0, 4'b1010}; // mispredict, repair
    vecs[5]  = '{5'b10000, 8'hFF, 3'd0, 4'b0000}; // push in RECOVER ignored
    vecs[6]  = '{5'b11000, 8'hFF, 3'd0, 4'b0000}; // stalled push ignored
    vecs[7]  = '{5'b10000, 8'hFE, 3'd1, 4'b0000};
    vecs[8]  = '{5'b10000, 8'hFC, 3'd2, 4'b0000};
    vecs[9]  = '{5'b10100, 8'hF9, 3'd3, 4'b0000};
    vecs[10] = '{5'b10000, 8'hF2, 3'd4, 4'b0100}; // full
    vecs[11] = '{5'b10100, 8'hF2, 3'd4, 4'b0100}; // push while full ignored
    vecs[12] = '{5'b10110, 8'hF2, 3'd3, 4'b0000}; // pop + push while full: push blocked
    vecs[13] = '{5'b10111, 8'hFD, 3'd0, 4'b1010}; // push + mispredict: push dropped
    vecs[14] = '{5'b00000, 8'hFD, 3'd0, 4'b0000};
    vecs[15] = '{5'b00010, 8'hFD, 3'd0, 4'b0001}; // resolve with nothing in flight
    vecs[16] = '{5'b00000, 8'hFD, 3'd0, 4'b0000};

    do_reset();
    chk_all("reset", 8'hFF, 3'd0, 4'b0000);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].in);
      chk_all($sformatf("vec%0d", i), vecs[i].ghr, vecs[i].infl, vecs[i].flags);
    end

    // Reset mid-operation with two branches in flight and a mispredicting resolve pending
    step(5'b10000);
    step(5'b10000);
    chk("pre-reset infl", int'(infl), 2);
    chk("pre-reset ghr",  int'(ghr),  int'(8'hF4));
    rst = 1'b1;
    {br, st, pr, vld, oc} = 5'b10011;
    @(posedge clk);
    #1;
    rst = 1'b0;
    {br, st, pr, vld, oc} = 5'b0;
    chk_all("midreset", 8'hFF, 3'd0, 4'b0000);
`ifdef GHR_PERF_CNT_EN
    chk("midreset bcnt", int'(bcnt), 0);
    chk("midreset mcnt", int'(mcnt), 0);
`endif

    // Random traffic against the queue model
    do_reset();
    q.delete();
    m_ghr   = (1 << W) - 1;
    m_recov = 0;
    m_bcnt  = 0;
    m_mcnt  = 0;
    for (int c = 0; c < 2000; c++) begin
      br  = ($urandom_range(1, 0) == 1);
      st  = ($urandom_range(3, 0) == 0);
      pr  = ($urandom_range(1, 0) == 1);
      vld = ($urandom_range(2, 0) == 0);
      oc  = ($urandom_range(1, 0) == 1);
      model_step(br, st, pr, vld, oc);
      @(posedge clk);
      #1;
      chk_all("rand", W'(m_ghr), 3'(q.size()),
              {m_misp, (q.size() == D), m_recov, m_err});
`ifdef GHR_PERF_CNT_EN
      chk("rand bcnt", int'(bcnt), int'(m_bcnt));
      chk("rand mcnt", int'(mcnt), int'(m_mcnt));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ghr_spec_ctrl.md
# ghr_spec_ctrl

Speculative-history controller for the branch predictor. Owns the global history register (GHR): shifts each DEC-stage prediction in speculatively, checkpoints the pre-shift history per in-flight branch, and repairs the GHR when the EX stage resolves a mispredict. It sits between the DEC/EX pipeline control and the counter-table index logic, and drives the history that the table uses.

## Interface
- BPRED_WIDTH, 8: GHR width in bits (≥2).
- CKPT_DEPTH, 4: in-flight branch checkpoints (power of 2, ≥2).
- i_Clk  in  1  rising-edge clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_DEC_Is_Branch  in  1  branch in DEC this cycle; one-cycle pulse per branch.
- i_DEC_Stall  in  1  DEC held; a branch is not accepted while high.
- i_Prediction  in  1  counter-table prediction for the DEC branch.
- i_ALU_Branch_Valid  in  1  oldest in-flight branch resolves this cycle.
- i_ALU_Branch_Outcome  in  1  actual direction (1 = taken).
- o_Global_History  out  BPRED_WIDTH  current speculative GHR.
- o_Mispredict  out  1  one-cycle pulse; resolved outcome ≠ stored prediction.
- o_Hist_Full  out  1  all checkpoints in use; DEC must stall branches.
- o_Recovering  out  1  high during RECOVER state.
- o_Inflight  out  $clog2(CKPT_DEPTH)+1  unresolved branch count.
- o_Resolve_Err  out  1  one-cycle pulse; resolve arrived with o_Inflight = 0.

## Operation
- Checkpoint entry = {pre-shift GHR, predicted bit}; FIFO order, oldest popped on resolve.
- Push accepted iff i_DEC_Is_Branch & !i_DEC_Stall & !o_Hist_Full & state==RUN & no mispredict this cycle. On push: GHR ← {GHR[W-2:0], i_Prediction}, entry written, count +1.
- Resolve (i_ALU_Branch_Valid, count>0): pop oldest. Correct: count −1, GHR untouched. Mispredict: GHR ← {ckpt_hist[W-2:0], i_ALU_Branch_Outcome}, all entries flushed (count ← 0), o_Mispredict pulses, state → RECOVER.
- Resolve with count = 0: no pop, GHR unchanged, o_Resolve_Err pulses.
- Simultaneous push + correct resolve: both applied; count unchanged; GHR shifts with new prediction.
- Simultaneous push + mispredict: push dropped (younger branch is being flushed); repair wins.
- o_Hist_Full = (count == CKPT_DEPTH), from registered count; push blocked while full even if a pop occurs that cycle.
- FSM: RUN → RECOVER on mispredict; RECOVER → RUN unconditionally after one cycle. In RECOVER pushes and resolves are ignored (pipeline flush cycle).
- Pointers wrap modulo CKPT_DEPTH; count saturates by construction (0..CKPT_DEPTH).

## Timing
- Reset values: GHR all ones (default taken), count 0, pointers 0, state RUN, all pulses 0, o_Hist_Full 0, o_Recovering 0.
- Reset mid-operation wins over every event in that cycle; all checkpoints discarded.
- GHR, count, state update on the edge after the qualifying input cycle; o_Global_History is a registered output (1-cycle latency).
- o_Mispredict and o_Resolve_Err registered; assert the cycle after the resolve.
- Mispredict compare uses the stored prediction bit, not the current i_Prediction.

## Configuration
- GHR_PERF_CNT_EN defined: adds outputs o_Branch_Cnt and o_Mispredict_Cnt (32 b each), counting accepted resolves and mispredicts, wrap at 2^32, cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package bpred_pkg: state enum (RUN, RECOVER), checkpoint struct typedef parameterised via BPRED_WIDTH, GHR reset constant (all ones).
- One sub-module: ghr_ckpt_fifo (synchronous FIFO with flush, push/pop, count); controller holds GHR, FSM and compare.

## Test plan
- Reset, then 3 pushes predicting 1,0,1 with GHR=0xFF → GHR 0xFD after third edge, o_Inflight=3.
- From above, resolve oldest with outcome 1 → no o_Mispredict, o_Inflight=2, GHR 0xFD.
- Then resolve next with outcome 1 (predicted 0) → o_Mispredict pulse, GHR=0xFF, o_Inflight=0, o_Recovering high one cycle; push during RECOVER ignored.
- Four pushes with CKPT_DEPTH=4 → o_Hist_Full=1; fifth push (stall low) ignored, GHR unchanged; correct resolve + push same cycle → push still blocked, count 3.
- Push + mispredicting resolve same cycle → push dropped, GHR = repaired value, count 0; resolve with count 0 → o_Resolve_Err pulse.
- Reset asserted with 2 in flight → next cycle GHR=0xFF, count 0, all pulses low; with GHR_PERF_CNT_EN, counters read 0.
